// File: rtl/ihp13_bist_pkg.sv
// Shared types, March C- element table and background constants for the SRAM BIST.
// Latency: none (declarations only).
// Backpressure: none; consumed by ihp13_sram_bist_ctrl and ihp13_bist_addr_gen.
package ihp13_bist_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } bist_state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  // rd: element starts with a read; wr: element writes; *_inv: use ~BG instead of BG.
  typedef struct packed {
    logic rd;
    logic wr;
    logic rd_inv;
    logic wr_inv;
  } elem_ops_t;

  localparam logic [63:0] BgSolid   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] BgChecker = 64'hAAAA_AAAA_AAAA_AAAA;

  // Operation table of March C-: M0 w(BG), M1 (rBG,w~BG), M2 (r~BG,wBG),
  // M3 (rBG,w~BG), M4 (r~BG,wBG), M5 rBG.
  function automatic elem_ops_t elem_ops(march_elem_e e);
    elem_ops_t o;
    case (e)
      M0:      o = '{rd: 1'b0, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b0};
      M1:      o = '{rd: 1'b1, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1};
      M2:      o = '{rd: 1'b1, wr: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
      M3:      o = '{rd: 1'b1, wr: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1};
      M4:      o = '{rd: 1'b1, wr: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
      M5:      o = '{rd: 1'b1, wr: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Address direction per element: only M3 and M4 walk downwards.
  function automatic logic elem_down(march_elem_e e);
    return (e == M3) || (e == M4);
  endfunction

endpackage

// File: rtl/ihp13_sram_bist_ctrl_if.sv
// A_BIST_* port group of one IHP13 1P x64 SRAM macro.
// Latency: dout is the macro's registered read data, valid one cycle after the read.
// Backpressure: none; the macro accepts one operation per cycle.
interface ihp13_sram_bist_ctrl_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64
);
  logic                 en;
  logic                 men;
  logic                 wen;
  logic                 ren;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] din;
  logic [DataWidth-1:0] bm;
  logic [DataWidth-1:0] dout;

  modport master (output en, men, wen, ren, addr, din, bm, input dout);
  modport slave  (input en, men, wen, ren, addr, din, bm, output dout);
endinterface

// File: rtl/ihp13_bist_addr_gen.sv
// Loadable up/down word-address counter for the March elements.
// Latency: load/step take effect on the next clock; last is combinational on the held address.
// Backpressure: none; the controller steps it at most once per cycle.
module ihp13_bist_addr_gen #(
  parameter int NumWords  = 256,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load,
  input  logic                 dir,
  input  logic                 step,
  output logic [AddrWidth-1:0] addr,
  output logic                 last
);

  localparam logic [AddrWidth-1:0] AddrMax = AddrWidth'(NumWords - 1);

  logic [AddrWidth-1:0] addr_q;
  logic                 dir_q;

  // Load the start address of the next element (dir latched for it), else walk one word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else if (load) begin
      addr_q <= dir ? AddrMax : '0;
      dir_q  <= dir;
    end else if (step) begin
      addr_q <= dir_q ? (addr_q - AddrWidth'(1)) : (addr_q + AddrWidth'(1));
    end
  end

  assign addr = addr_q;
  assign last = dir_q ? (addr_q == '0) : (addr_q == AddrMax);

endmodule

// File: rtl/ihp13_sram_bist_ctrl.sv
// March C- BIST initiator for one IHP13 1P x64 SRAM macro; macro IHP13_SRAM_BIST_CHECKERBOARD_EN adds a 0xAA.. pass.
// Latency: 10*NumWords op cycles plus one drain cycle per pass; done_o the cycle after the last drain.
// Backpressure: none; one macro op every cycle while running, start_i ignored while busy.
module ihp13_sram_bist_ctrl
  import ihp13_bist_pkg::*;
#(
  parameter int NumWords  = 256,
  parameter int DataWidth = 64,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [2:0]             fail_elem_o,
`ifdef IHP13_SRAM_BIST_CHECKERBOARD_EN
  output logic                   fail_pass_o,
`endif
  ihp13_sram_bist_ctrl_if.master bist
);

  bist_state_e          state_q, state_d;
  march_elem_e          elem_q, next_elem, cmp_elem_q;
  elem_ops_t            ops;
  logic                 ph_q, run, start_acc, pair, is_rd, step, elem_end, last_pass;
  logic                 gen_load, gen_dir, gen_last;
  logic [AddrWidth-1:0] gen_addr, cmp_addr_q, fail_addr_q;
  logic [DataWidth-1:0] bg, rd_data, wr_data, exp_q;
  logic                 chk_q, fail_q, capture;
  logic [2:0]           fail_elem_q;

  assign ops       = elem_ops(elem_q);
  assign run       = (state_q == StRun);
  assign start_acc = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign pair      = ops.rd && ops.wr;
  // Pair elements read in phase 0 and write the same word in phase 1.
  assign is_rd     = ops.rd && !ph_q;
  assign step      = run && (!pair || ph_q);
  assign elem_end  = step && gen_last;
  assign next_elem = (elem_q == M5) ? M0 : march_elem_e'(elem_q + 3'd1);
  // Address reload happens on the element's last op, so there is no bubble between elements.
  assign gen_load  = start_acc || elem_end;
  assign gen_dir   = start_acc ? 1'b0 : elem_down(next_elem);
  assign rd_data   = ops.rd_inv ? ~bg : bg;
  assign wr_data   = ops.wr_inv ? ~bg : bg;
  assign capture   = chk_q && (bist.dout != exp_q) && !fail_q;

  ihp13_bist_addr_gen #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (gen_load),
    .dir    (gen_dir),
    .step   (step),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state: drain one cycle after the last M5 read so its data can be compared.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_i) state_d = StRun;
      StRun:          if (elem_end && (elem_q == M5)) state_d = StDrain;
      StDrain:        state_d = last_pass ? StDone : StRun;
      default:        state_d = StIdle;
    endcase
  end

  // Outputs: macro port driven only while running; everything quiet otherwise.
  always_comb begin
    busy_o    = (state_q == StRun) || (state_q == StDrain);
    done_o    = (state_q == StDone);
    bist.en   = busy_o;
    bist.men  = run;
    bist.ren  = run && is_rd;
    bist.wen  = run && !is_rd;
    bist.addr = run ? gen_addr : '0;
    bist.din  = (run && !is_rd) ? wr_data : '0;
    bist.bm   = busy_o ? '1 : '0;
  end

  // Element and read/write phase tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q <= M0;
      ph_q   <= 1'b0;
    end else if (start_acc) begin
      elem_q <= M0;
      ph_q   <= 1'b0;
    end else if (step) begin
      ph_q <= 1'b0;
      if (gen_last) elem_q <= next_elem;
    end else if (run) begin
      ph_q <= 1'b1;
    end
  end

  // Remember what each read must return; the macro answers one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_q      <= 1'b0;
      exp_q      <= '0;
      cmp_addr_q <= '0;
      cmp_elem_q <= M0;
    end else begin
      chk_q <= run && is_rd;
      if (run && is_rd) begin
        exp_q      <= rd_data;
        cmp_addr_q <= gen_addr;
        cmp_elem_q <= elem_q;
      end
    end
  end

  // Sticky verdict holding the first mismatch; a new run clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if (start_acc) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if (capture) begin
      fail_q      <= 1'b1;
      fail_addr_q <= cmp_addr_q;
      fail_elem_q <= cmp_elem_q;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

`ifdef IHP13_SRAM_BIST_CHECKERBOARD_EN
  logic pass_q, cmp_pass_q, fail_pass_q;

  assign last_pass   = pass_q;
  assign bg          = pass_q ? BgChecker : BgSolid;
  assign fail_pass_o = fail_pass_q;

  // Pass index: solid background first, checkerboard after the first drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  pass_q <= 1'b0;
    else if (start_acc)           pass_q <= 1'b0;
    else if (state_q == StDrain)  pass_q <= 1'b1;
  end

  // Pass of the pending read and of the first mismatch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_pass_q  <= 1'b0;
      fail_pass_q <= 1'b0;
    end else begin
      if (run && is_rd) cmp_pass_q <= pass_q;
      if (start_acc)    fail_pass_q <= 1'b0;
      else if (capture) fail_pass_q <= cmp_pass_q;
    end
  end
`else
  assign last_pass = 1'b1;
  assign bg        = BgSolid;
`endif

endmodule
